// File: rtl/game_ctrl.sv
// Board game sequencer: owns the 8x8 colour board, the cursor and the MENU/PLAY/SETTLE flow
// that drives the VGA renderer. All outputs are registered.
module game_ctrl #(
  parameter int          SETTLE_CYCLES = 100000000,
  parameter logic [11:0] P0_COLOR      = 12'hF80,
  parameter logic [11:0] P1_COLOR      = 12'h08F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_ok,
  input  logic         btn_back,
  output logic [1:0]   state,
  output logic [3:0]   cursor_x,
  output logic [3:0]   cursor_y,
  output logic [767:0] board_data,
  output logic         player,
  output logic [6:0]   move_cnt
);

  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_MENU   = 2'b00,
    S_PLAY   = 2'b01,
    S_SETTLE = 2'b10
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    cx_reg, cx_next;
  logic [2:0]    cy_reg, cy_next;
  logic          player_reg, player_next;
  logic [6:0]    cnt_reg, cnt_next;
  logic [TW-1:0] timer_reg, timer_next;

  logic [11:0]   cell_reg [64];
  logic          clear;
  logic          wr_en;
  logic [11:0]   wr_data;
  logic [5:0]    cur_addr;
  logic          cur_empty;

  assign cur_addr  = {cy_reg, cx_reg};
  assign cur_empty = (cell_reg[cur_addr] == 12'h000);

  always_comb begin
    state_next  = state_reg;
    cx_next     = cx_reg;
    cy_next     = cy_reg;
    player_next = player_reg;
    cnt_next    = cnt_reg;
    timer_next  = timer_reg;
    clear       = 1'b0;
    wr_en       = 1'b0;
    wr_data     = P0_COLOR;
    case (state_reg)
      S_MENU: begin
        if (btn_ok) begin
          state_next  = S_PLAY;
          clear       = 1'b1;
          cx_next     = 3'd0;
          cy_next     = 3'd0;
          player_next = 1'b0;
          cnt_next    = 7'd0;
        end
      end
      S_PLAY: begin
        if (btn_back) begin
          state_next = S_MENU;
        end else if (btn_ok) begin
          // Placing on an occupied cell is silently rejected
          if (cur_empty) begin
            wr_en       = 1'b1;
            wr_data     = player_reg ? P1_COLOR : P0_COLOR;
            player_next = ~player_reg;
            cnt_next    = cnt_reg + 7'd1;
            if (cnt_reg == 7'd63) begin
              state_next = S_SETTLE;
              timer_next = '0;
            end
          end
        end else begin
          if (btn_right && !btn_left && cx_reg != 3'd7)
            cx_next = cx_reg + 3'd1;
          else if (btn_left && !btn_right && cx_reg != 3'd0)
            cx_next = cx_reg - 3'd1;
          if (btn_down && !btn_up && cy_reg != 3'd7)
            cy_next = cy_reg + 3'd1;
          else if (btn_up && !btn_down && cy_reg != 3'd0)
            cy_next = cy_reg - 3'd1;
        end
      end
      S_SETTLE: begin
        if (btn_ok || btn_back || timer_reg == TIMER_LAST) begin
          state_next = S_MENU;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        state_next = S_MENU;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_MENU;
      cx_reg     <= 3'd0;
      cy_reg     <= 3'd0;
      player_reg <= 1'b0;
      cnt_reg    <= 7'd0;
      timer_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cx_reg     <= cx_next;
      cy_reg     <= cy_next;
      player_reg <= player_next;
      cnt_reg    <= cnt_next;
      timer_reg  <= timer_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 64; i++) begin
      if (rst || clear)
        cell_reg[i] <= 12'h000;
      else if (wr_en && cur_addr == 6'(i))
        cell_reg[i] <= wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_board
      assign board_data[gi*12 +: 12] = cell_reg[gi];
    end
  endgenerate

  assign state    = state_reg;
  assign cursor_x = {1'b0, cx_reg};
  assign cursor_y = {1'b0, cy_reg};
  assign player   = player_reg;
  assign move_cnt = cnt_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: scripted game scenarios plus random button traffic,
// compared every cycle against a rule-level model of the game.
module tb_game_ctrl;
  localparam int SC = 16;
  localparam logic [5:0] UP = 6'b100000, DOWN = 6'b010000, LEFT = 6'b001000,
                         RIGHT = 6'b000100, OK = 6'b000010, BACK = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_ok = 0, btn_back = 0;
  logic [1:0]   state;
  logic [3:0]   cursor_x, cursor_y;
  logic [767:0] board_data;
  logic         player;
  logic [6:0]   move_cnt;

  int tests = 0;
  int fails = 0;

  game_ctrl #(.SETTLE_CYCLES(SC), .P0_COLOR(12'hF80), .P1_COLOR(12'h08F)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_ok(btn_ok), .btn_back(btn_back),
    .state(state), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .board_data(board_data), .player(player), .move_cnt(move_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: game rules on plain integers
  int m_board [64];
  int m_x, m_y, m_player, m_cnt, m_st, m_timer;
  bit m_valid = 0;

  function automatic int clamp7(input int v);
    return (v < 0) ? 0 : (v > 7) ? 7 : v;
  endfunction

  function automatic logic [767:0] m_pack();
    logic [767:0] v;
    for (int k = 0; k < 64; k++) v[k*12 +: 12] = 12'(m_board[k]);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_board[k]) m_board[k] = 0;
      m_x = 0; m_y = 0; m_player = 0; m_cnt = 0; m_st = 0; m_timer = 0;
      m_valid = 1;
    end else if (m_st == 0) begin
      if (btn_ok) begin
        foreach (m_board[k]) m_board[k] = 0;
        m_x = 0; m_y = 0; m_player = 0; m_cnt = 0; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (btn_back) m_st = 0;
      else if (btn_ok) begin
        if (m_board[m_y*8 + m_x] == 0) begin
          m_board[m_y*8 + m_x] = (m_player == 0) ? 'hF80 : 'h08F;
          m_player = 1 - m_player;
          m_cnt++;
          if (m_cnt == 64) begin m_st = 2; m_timer = 0; end
        end
      end else begin
        m_x = clamp7(m_x + int'(btn_right) - int'(btn_left));
        m_y = clamp7(m_y + int'(btn_down) - int'(btn_up));
      end
    end else begin
      if (btn_ok || btn_back || m_timer == SC - 1) begin m_st = 0; m_timer = 0; end
      else m_timer++;
    end
  end

  task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("state", 768'(state), 768'(m_st));
      chk("cursor_x", 768'(cursor_x), 768'(m_x));
      chk("cursor_y", 768'(cursor_y), 768'(m_y));
      chk("player", 768'(player), 768'(m_player));
      chk("move_cnt", 768'(move_cnt), 768'(m_cnt));
      chk("board", board_data, m_pack());
    end
  end

  task automatic press(input logic [5:0] b);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right, btn_ok, btn_back} = b;
    @(posedge clk);
    #1;
    {btn_up, btn_down, btn_left, btn_right, btn_ok, btn_back} = 6'b0;
    $display("[TB] t=%0t btn=%b state=%b x=%0d y=%0d cnt=%0d", $time, b, state,
             cursor_x, cursor_y, move_cnt);
  endtask

  // Row-major fill from (0,0); cell k receives the k-th stone
  task automatic fill();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        press(OK);
        if (c < 7) press(RIGHT);
      end
      if (r < 7) begin
        press(DOWN);
        repeat (7) press(LEFT);
      end
    end
  endtask

  initial begin
    logic [5:0] b;
    repeat (2) press(6'b0);
    rst = 1'b0;
    chk("rst_state", 768'(state), 768'(2'b00));
    chk("rst_board", board_data, 768'(0));
    chk("rst_cnt", 768'(move_cnt), 768'(0));

    press(OK);
    chk("start_state", 768'(state), 768'(2'b01));
    chk("start_cursor", 768'({cursor_x, cursor_y}), 768'(8'h00));

    repeat (3) press(RIGHT);
    repeat (2) press(DOWN);
    press(OK);
    chk("cell19", 768'(board_data[239:228]), 768'(12'hF80));
    chk("p_after1", 768'(player), 768'(1));
    chk("cnt_after1", 768'(move_cnt), 768'(1));
    press(OK);
    chk("cell19_again", 768'(board_data[239:228]), 768'(12'hF80));
    chk("cnt_again", 768'(move_cnt), 768'(1));

    repeat (3) press(LEFT);
    repeat (2) press(UP);
    press(LEFT | UP);
    chk("sat_zero", 768'({cursor_x, cursor_y}), 768'(8'h00));
    repeat (10) press(RIGHT);
    chk("sat_seven", 768'(cursor_x), 768'(7));
    press(LEFT | RIGHT);
    chk("lr_cancel", 768'(cursor_x), 768'(7));

    press(BACK);
    press(OK);
    fill();
    chk("fill_state", 768'(state), 768'(2'b10));
    chk("fill_cnt", 768'(move_cnt), 768'(64));
    for (int k = 0; k < 64; k++)
      chk("fill_color", 768'(board_data[k*12 +: 12]), 768'((k % 2) ? 12'h08F : 12'hF80));
    repeat (SC - 1) press(6'b0);
    chk("settle_hold", 768'(state), 768'(2'b10));
    press(6'b0);
    chk("settle_timeout", 768'(state), 768'(2'b00));
    chk("board_kept", 768'(board_data[767:756]), 768'(12'h08F));

    press(OK);
    for (int i = 0; i < 5; i++) begin press(OK); press(RIGHT); end
    press(BACK);
    chk("abort_state", 768'(state), 768'(2'b00));
    chk("abort_cnt", 768'(move_cnt), 768'(5));
    press(OK);
    chk("restart_board", board_data, 768'(0));

    fill();
    repeat (7) press(6'b0);
    rst = 1'b1;
    press(DOWN | OK);
    rst = 1'b0;
    chk("rst_settle_state", 768'(state), 768'(2'b00));
    chk("rst_settle_board", board_data, 768'(0));
    chk("rst_settle_misc", 768'({cursor_x, cursor_y, player, move_cnt}), 768'(0));

    for (int i = 0; i < 20000; i++) begin
      b[5] = ($urandom_range(0, 2) == 0);
      b[4] = ($urandom_range(0, 2) == 0);
      b[3] = ($urandom_range(0, 2) == 0);
      b[2] = ($urandom_range(0, 2) == 0);
      b[1] = ($urandom_range(0, 4) == 0);
      b[0] = ($urandom_range(0, 999) == 0);
      rst = ($urandom_range(0, 4999) == 0);
      press(b);
    end
    rst = 1'b0;
    press(6'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
